vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator: consumes HSync/VSync pulses and reconstructs horizontal/vertical position counters, an active-video flag, a frame-start strobe and a lock indicator.
- Lets a capture or loopback path, or a second display pipeline, recover pixel coordinates from sync alone.
- Sits between the VGA sync inputs and any pixel consumer.
- Default timing is 640x480 @ 800x525 total, active-low syncs.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/sync_edge_detect.sv | 24 ++
 rtl/vga_sync_decoder.sv | 123 ++++++++++++
 tb/tb_vga_sync_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480 @ 800x525 VGA timing constants shared by the sync generator and the sync decoder.
// Pure constants/types; no latency, no flow control.
package vga_timing_pkg;

  localparam int POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam int H_ACTIVE_START = H_SYNC + H_BACK;
  localparam int V_ACTIVE_START = V_SYNC + V_BACK;

  localparam int LOCK_LINES  = 4;
  localparam int LOCK_FRAMES = 2;

  function automatic logic in_window(pos_t pos, int start, int len);
    return (int'(pos) >= start) && (int'(pos) < start + len);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop sync sampler with combinational falling-edge strobe; strobe is high the cycle after the pin samples low.
// No backpressure; sample flops reset high so a released reset never produces an edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic fall_o
);

  logic r1_q, r2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_q <= 1'b1;
      r2_q <= 1'b1;
    end else begin
      r1_q <= sync_i;
      r2_q <= r1_q;
    end
  end

  assign fall_o = r2_q & ~r1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds HPos/VPos, active flag, frame-start strobe and lock from active-low HSync/VSync.
// HPos reads 0 two edges after HSync first samples low; free-running, no backpressure.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL        = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL        = vga_timing_pkg::V_TOTAL,
  parameter int H_ACTIVE_START = vga_timing_pkg::H_ACTIVE_START,
  parameter int H_ACTIVE       = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE_START = vga_timing_pkg::V_ACTIVE_START,
  parameter int V_ACTIVE       = vga_timing_pkg::V_ACTIVE,
  parameter int LOCK_LINES     = vga_timing_pkg::LOCK_LINES,
  parameter int LOCK_FRAMES    = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic [9:0] o_HPos,
  output logic [9:0] o_VPos,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_Locked
);

  localparam int HL_W = $clog2(LOCK_LINES + 1);
  localparam int VL_W = $clog2(LOCK_FRAMES + 1);
  localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
  localparam logic [HL_W-1:0] HL_MAX = HL_W'(LOCK_LINES);
  localparam logic [VL_W-1:0] VL_MAX = VL_W'(LOCK_FRAMES);

  logic h_edge, v_edge;
  logic h_wrap, line_start, frame_evt;

  pos_t            hpos_q, hpos_d, vpos_q, vpos_d;
  logic            pend_q, pend_d;
  logic            active_q, active_d;
  logic            fs_q, fs_d;
  logic            locked_q, locked_d;
  logic [HL_W-1:0] hlock_q, hlock_d;
  logic [VL_W-1:0] vlock_q, vlock_d;

  sync_edge_detect u_hsync_edge (
    .clk_i  (i_Clk),
    .rst_i  (i_Reset),
    .sync_i (i_HSync),
    .fall_o (h_edge)
  );

  sync_edge_detect u_vsync_edge (
    .clk_i  (i_Clk),
    .rst_i  (i_Reset),
    .sync_i (i_VSync),
    .fall_o (v_edge)
  );

  always_comb begin
    h_wrap     = (hpos_q == H_LAST);
    line_start = h_edge | h_wrap;
    frame_evt  = h_edge & (pend_q | v_edge);

    hpos_d  = line_start ? '0 : hpos_q + pos_t'(1);
    vpos_d  = vpos_q;
    pend_d  = pend_q;
    hlock_d = hlock_q;
    vlock_d = vlock_q;
    fs_d    = frame_evt;

    // A VSync edge only arms the frame start; the next real HSync edge consumes it.
    if (v_edge)    pend_d = 1'b1;
    if (frame_evt) pend_d = 1'b0;

    if (line_start) begin
      if (frame_evt)             vpos_d = '0;
      else if (vpos_q == V_LAST) vpos_d = '0;
      else                       vpos_d = vpos_q + pos_t'(1);
    end

    if (h_edge)
      hlock_d = !h_wrap ? '0 : (hlock_q == HL_MAX) ? HL_MAX : hlock_q + HL_W'(1);
    else if (h_wrap)
      hlock_d = '0;

    if (frame_evt)
      vlock_d = (vpos_q != V_LAST) ? '0 : (vlock_q == VL_MAX) ? VL_MAX : vlock_q + VL_W'(1);
    else if (line_start && vpos_q == V_LAST)
      vlock_d = '0;

    active_d = in_window(hpos_d, H_ACTIVE_START, H_ACTIVE) &&
               in_window(vpos_d, V_ACTIVE_START, V_ACTIVE);
    locked_d = (hlock_d == HL_MAX) && (vlock_d == VL_MAX);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      hlock_q  <= '0;
      vlock_q  <= '0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      hlock_q  <= hlock_d;
      vlock_q  <= vlock_d;
    end
  end

  assign o_HPos        = hpos_q;
  assign o_VPos        = vpos_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = fs_q;
  assign o_Locked      = locked_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 40x15 raster driven by a tiny in-bench sync generator.
module tb_vga_sync_decoder;

  localparam int H  = 40;
  localparam int V  = 15;
  localparam int HS = 4;
  localparam int VS = 2;
  localparam int HA0 = 8;
  localparam int HA  = 24;
  localparam int VA0 = 4;
  localparam int VA  = 8;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_HSync = 1'b1;
  logic       i_VSync = 1'b1;
  logic [9:0] o_HPos, o_VPos;
  logic       o_Active, o_Frame_Start, o_Locked;

  vga_sync_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .H_ACTIVE_START(HA0), .H_ACTIVE(HA),
    .V_ACTIVE_START(VA0), .V_ACTIVE(VA), .LOCK_LINES(4), .LOCK_FRAMES(2)
  ) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .o_HPos(o_HPos), .o_VPos(o_VPos), .o_Active(o_Active),
    .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Generator position most recently driven onto the pins.
  int gh = H - 1;
  int gv = V - 1;
  bit h_en = 1'b1;
  bit v_mid = 1'b0;
  bit short_line = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (gen h=%0d v=%0d)", tag, obs, exp, gh, gv);
    end
  endtask

  task automatic apply_next();
    if (gh == H - 1 || (short_line && gh == H - 2)) begin
      gh = 0;
      short_line = 1'b0;
      gv = (gv == V - 1) ? 0 : gv + 1;
    end else begin
      gh = gh + 1;
    end
    i_HSync = !(h_en && gh < HS);
    i_VSync = v_mid ? !((gv == 0 && gh >= 20) || gv == 1 || (gv == 2 && gh < 20))
                    : !(gv < VS);
  endtask

  task automatic adv();
    apply_next();
    @(negedge clk);
  endtask

  // Decoder trails the pins by two edges, so it shows the position one behind the last drive.
  function automatic int exp_h();
    return (gh == 0) ? H - 1 : gh - 1;
  endfunction

  function automatic int exp_v();
    if (gh != 0) return gv;
    return (gv == 0) ? V - 1 : gv - 1;
  endfunction

  task automatic run_until(input int th, input int tv, input bit pos_chk);
    int n = 0;
    while (!(gh == th && gv == tv) && n < 2 * H * V) begin
      adv();
      n++;
      if (pos_chk) begin
        check("hpos", o_HPos, exp_h());
        check("vpos", o_VPos, exp_v());
      end
    end
    if (n >= 2 * H * V) check("run_until_timeout", n, 0);
  endtask

  task automatic run_to_lock(input string tag);
    int nfs = 0;
    bit prev = 1'b0;
    for (int i = 0; i < 4 * H * V && nfs < 3; i++) begin
      adv();
      if (o_Frame_Start) begin
        nfs++;
        check({tag, "_lock_at_fs"}, o_Locked, int'(nfs >= 3));
        if (nfs == 3) check({tag, "_unlocked_before"}, prev, 0);
      end
      prev = o_Locked;
    end
    check({tag, "_fs_count"}, nfs, 3);
  endtask

  initial begin
    int nfs;
    int fa_h, fa_v;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_hpos", o_HPos, 0);
    check("rst_vpos", o_VPos, 0);
    check("rst_active", o_Active, 0);
    check("rst_fs", o_Frame_Start, 0);
    check("rst_locked", o_Locked, 0);

    // Clean timing from reset: lock arrives with the third frame start.
    i_Reset = 1'b0;
    run_to_lock("init");
    check("init_fs_hpos", o_HPos, 0);
    check("init_fs_vpos", o_VPos, 0);

    seen = 1'b0;
    fa_h = -1;
    fa_v = -1;
    for (int i = 0; i < H * V; i++) begin
      adv();
      check("frm_hpos", o_HPos, exp_h());
      check("frm_vpos", o_VPos, exp_v());
      check("frm_active", o_Active,
            int'(exp_h() >= HA0 && exp_h() < HA0 + HA && exp_v() >= VA0 && exp_v() < VA0 + VA));
      check("frm_fs", o_Frame_Start, int'(exp_h() == 0 && exp_v() == 0));
      check("frm_locked", o_Locked, 1);
      if (o_Active && !seen) begin
        seen = 1'b1;
        fa_h = int'(o_HPos);
        fa_v = int'(o_VPos);
      end
    end
    check("first_active_h", fa_h, HA0);
    check("first_active_v", fa_v, VA0);

    // HSync stops: freewheel wrap, lock drops, VPos keeps counting; then relock after 4 lines.
    run_until(H - 1, 4, 1'b1);
    h_en = 1'b0;
    adv();
    check("fw_hpos_last", o_HPos, H - 1);
    check("fw_locked_before_wrap", o_Locked, 1);
    adv();
    check("fw_hpos_wrap", o_HPos, 0);
    check("fw_vpos_wrap", o_VPos, 5);
    check("fw_unlock", o_Locked, 0);
    run_until(H - 1, 6, 1'b1);
    check("fw_still_unlocked", o_Locked, 0);
    h_en = 1'b1;
    run_until(1, 9, 1'b1);
    check("fw_relock_3lines", o_Locked, 0);
    run_until(1, 10, 1'b1);
    check("fw_relock_4lines", o_Locked, 1);

    // One short line: the early edge at HPos=H-2 reloads 0 and costs the lock.
    run_until(5, 11, 1'b1);
    short_line = 1'b1;
    run_until(H - 2, 11, 1'b1);
    adv();
    check("short_hpos_pre", o_HPos, H - 2);
    check("short_locked_pre", o_Locked, 1);
    adv();
    check("short_hpos_load", o_HPos, 0);
    check("short_vpos", o_VPos, 12);
    check("short_unlock", o_Locked, 0);
    run_until(1, 0, 1'b1);
    check("short_relock_3lines", o_Locked, 0);
    run_until(1, 1, 1'b1);
    check("short_relock_4lines", o_Locked, 1);

    // VSync falls mid-line: frame start waits for the next HSync edge and pulses once.
    run_until(0, 10, 1'b1);
    v_mid = 1'b1;
    nfs = 0;
    for (int i = 0; i < 2 * H * V && !(gh == 0 && gv == 4); i++) begin
      adv();
      if (gh == 1 && gv == 0) begin
        check("mid_no_fs_line0", o_Frame_Start, 0);
        check("mid_vpos_wrap", o_VPos, 0);
        check("mid_unlock_v_wrap", o_Locked, 0);
      end
      if (o_Frame_Start) begin
        nfs++;
        check("mid_fs_gen_h", gh, 1);
        check("mid_fs_gen_v", gv, 1);
        check("mid_fs_hpos", o_HPos, 0);
        check("mid_fs_vpos", o_VPos, 0);
      end
    end
    check("mid_fs_count", nfs, 1);
    v_mid = 1'b0;

    // One-cycle reset mid-frame with syncs inactive.
    run_until(15, 7, 1'b0);
    i_Reset = 1'b1;
    adv();
    check("mrst_hpos", o_HPos, 0);
    check("mrst_vpos", o_VPos, 0);
    check("mrst_active", o_Active, 0);
    check("mrst_fs", o_Frame_Start, 0);
    check("mrst_locked", o_Locked, 0);
    i_Reset = 1'b0;
    adv();
    check("mrst_hpos_1", o_HPos, 1);
    check("mrst_fs_1", o_Frame_Start, 0);
    adv();
    adv();
    check("mrst_hpos_3", o_HPos, 3);
    check("mrst_vpos_3", o_VPos, 0);
    check("mrst_fs_3", o_Frame_Start, 0);
    check("mrst_locked_3", o_Locked, 0);
    run_to_lock("mrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
